// File: rtl/vga_sprite_engine.sv
// ---------------------------------------------------------------------------
// vga_sprite_engine
//
// VGA timing generator with a small table of filled rectangles ("sprites")
// drawn over a solid background colour.
//
// A free-running divider turns pclk into a pixel tick. Each tick advances the
// horizontal and vertical counters. The visible pixel for the current
// counter position is computed combinationally, then registered on the same
// tick. Every output therefore changes together, exactly one tick after the
// counters, and holds its value between ticks.
//
// Rectangles are written into a pending table at any time. The whole pending
// table is copied to the live table on the last tick of a frame, so a frame
// is always drawn from one consistent table.
//
// Ports
//   pclk        : sole clock
//   reset_n     : asynchronous active-low reset
//   bg_color    : RGB565 background colour
//   wr_en       : rectangle table write strobe (any pclk cycle)
//   wr_idx      : channel written; values >= NUM_RECT are ignored
//   wr_x, wr_y  : logical top-left corner
//   wr_w, wr_h  : logical size (0 in either axis disables the channel)
//   wr_color    : RGB565 fill colour
//   hsync/vsync : sync outputs, asserted level = SYNC_POL
//   red/green/blue : pixel colour (zero outside active video)
//   active      : visible pixel
//   pix_x/pix_y : logical coordinate of the output pixel (zero outside active)
//   frame_start : one-pclk pulse as the counters move to (0,0)
// ---------------------------------------------------------------------------
module vga_sprite_engine #(
    parameter int   CLK_DIV     = 5,
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   SCALE_SHIFT = 1,
    parameter int   NUM_RECT    = 3,
    localparam int  IDX_W       = (NUM_RECT > 1) ? $clog2(NUM_RECT) : 1
) (
    input  logic             pclk,
    input  logic             reset_n,
    input  logic [15:0]      bg_color,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [9:0]       wr_x,
    input  logic [9:0]       wr_y,
    input  logic [9:0]       wr_w,
    input  logic [9:0]       wr_h,
    input  logic [15:0]      wr_color,
    output logic             hsync,
    output logic             vsync,
    output logic [4:0]       red,
    output logic [5:0]       green,
    output logic [4:0]       blue,
    output logic             active,
    output logic [9:0]       pix_x,
    output logic [9:0]       pix_y,
    output logic             frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W     = $clog2(H_TOTAL);
    localparam int VC_W     = $clog2(V_TOTAL);
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    // ---------------- timing counters ----------------
    logic [DIV_W-1:0] div_q, div_d;
    logic [HC_W-1:0]  hcount_q, hcount_d;
    logic [VC_W-1:0]  vcount_q, vcount_d;
    logic             tick;
    logic             h_last;
    logic             v_last;
    logic             frame_last;

    assign tick       = (32'(div_q) == CLK_DIV - 1);
    assign h_last     = (32'(hcount_q) == H_TOTAL - 1);
    assign v_last     = (32'(vcount_q) == V_TOTAL - 1);
    // Last tick of the frame: live table is refreshed and frame_start fires.
    assign frame_last = tick && h_last && v_last;

    always_comb begin
        div_d    = tick ? '0 : div_q + DIV_W'(1);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (tick) begin
            if (h_last) begin
                hcount_d = '0;
                vcount_d = v_last ? '0 : vcount_q + VC_W'(1);
            end else begin
                hcount_d = hcount_q + HC_W'(1);
            end
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            div_q    <= div_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    // ---------------- rectangle tables ----------------
    logic [9:0]  pend_x_q [NUM_RECT];
    logic [9:0]  pend_y_q [NUM_RECT];
    logic [9:0]  pend_w_q [NUM_RECT];
    logic [9:0]  pend_h_q [NUM_RECT];
    logic [15:0] pend_c_q [NUM_RECT];
    logic [9:0]  live_x_q [NUM_RECT];
    logic [9:0]  live_y_q [NUM_RECT];
    logic [9:0]  live_w_q [NUM_RECT];
    logic [9:0]  live_h_q [NUM_RECT];
    logic [15:0] live_c_q [NUM_RECT];

    // The live copy reads pending before this edge's write lands, so a write
    // on the commit tick waits for the following frame.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_RECT; i++) begin
                pend_x_q[i] <= '0;
                pend_y_q[i] <= '0;
                pend_w_q[i] <= '0;
                pend_h_q[i] <= '0;
                pend_c_q[i] <= '0;
                live_x_q[i] <= '0;
                live_y_q[i] <= '0;
                live_w_q[i] <= '0;
                live_h_q[i] <= '0;
                live_c_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RECT; i++) begin
                if (wr_en && (32'(wr_idx) == i)) begin
                    pend_x_q[i] <= wr_x;
                    pend_y_q[i] <= wr_y;
                    pend_w_q[i] <= wr_w;
                    pend_h_q[i] <= wr_h;
                    pend_c_q[i] <= wr_color;
                end
                if (frame_last) begin
                    live_x_q[i] <= pend_x_q[i];
                    live_y_q[i] <= pend_y_q[i];
                    live_w_q[i] <= pend_w_q[i];
                    live_h_q[i] <= pend_h_q[i];
                    live_c_q[i] <= pend_c_q[i];
                end
            end
        end
    end

    // ---------------- pixel computation ----------------
    logic                vid_active;
    logic                hs_zone;
    logic                vs_zone;
    logic [9:0]          log_x;
    logic [9:0]          log_y;
    logic [NUM_RECT-1:0] hit_vec;
    logic                hit_found;
    logic [15:0]         pix_color;

    assign vid_active = (32'(hcount_q) < H_ACTIVE) && (32'(vcount_q) < V_ACTIVE);
    assign hs_zone    = (32'(hcount_q) >= HS_START) && (32'(hcount_q) < HS_END);
    assign vs_zone    = (32'(vcount_q) >= VS_START) && (32'(vcount_q) < VS_END);
    assign log_x      = 10'(hcount_q >> SCALE_SHIFT);
    assign log_y      = 10'(vcount_q >> SCALE_SHIFT);

    // Bounds are 11 bits so rx+w never wraps back to the left edge.
    // A zero width or height gives an empty interval and never hits.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_RECT; i++) begin
            hit_vec[i] = ({1'b0, log_x} >= {1'b0, live_x_q[i]}) &&
                         ({1'b0, log_x} <  ({1'b0, live_x_q[i]} + {1'b0, live_w_q[i]})) &&
                         ({1'b0, log_y} >= {1'b0, live_y_q[i]}) &&
                         ({1'b0, log_y} <  ({1'b0, live_y_q[i]} + {1'b0, live_h_q[i]}));
        end
    end

    // Lowest hit index wins.
    always_comb begin
        hit_found = 1'b0;
        pix_color = bg_color;
        for (int i = 0; i < NUM_RECT; i++) begin
            if (!hit_found && hit_vec[i]) begin
                hit_found = 1'b1;
                pix_color = live_c_q[i];
            end
        end
    end

    // ---------------- registered outputs ----------------
    logic        hsync_q;
    logic        vsync_q;
    logic [15:0] rgb_q;
    logic        active_q;
    logic [9:0]  pix_x_q;
    logic [9:0]  pix_y_q;
    logic        frame_start_q;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            rgb_q         <= '0;
            active_q      <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_last;
            if (tick) begin
                hsync_q  <= hs_zone ? SYNC_POL : ~SYNC_POL;
                vsync_q  <= vs_zone ? SYNC_POL : ~SYNC_POL;
                active_q <= vid_active;
                rgb_q    <= vid_active ? pix_color : 16'h0000;
                pix_x_q  <= vid_active ? log_x : 10'd0;
                pix_y_q  <= vid_active ? log_y : 10'd0;
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = rgb_q[15:11];
    assign green       = rgb_q[10:5];
    assign blue        = rgb_q[4:0];
    assign active      = active_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sprite_engine.sv
`timescale 1ns/1ps
// Bench for vga_sprite_engine using a shrunken timing set so whole frames
// fit in a short run: 24 x 17 ticks per frame, 2 pclk per tick.
module tb_vga_sprite_engine;

    localparam int       CLK_DIV = 2;
    localparam int       HA = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int       VA = 12, VFP = 1, VSW = 2, VBP = 2;
    localparam bit       POL = 1'b0;
    localparam int       SS = 1;
    localparam int       NR = 3;
    localparam int       HT = HA + HFP + HSW + HBP;
    localparam int       VT = VA + VFP + VSW + VBP;
    localparam int       FRAME = HT * VT;
    localparam int       FP_CYC = FRAME * CLK_DIV;
    localparam logic [39:0] RST_VEC = {!POL, !POL, 38'd0};

    // ---------------- clock / reset / DUT ----------------
    logic        pclk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] bg_color = 16'h0000;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_idx = 2'd0;
    logic [9:0]  wr_x = 10'd0, wr_y = 10'd0, wr_w = 10'd0, wr_h = 10'd0;
    logic [15:0] wr_color = 16'h0000;
    logic        hsync, vsync, active, frame_start;
    logic [4:0]  red, blue;
    logic [5:0]  green;
    logic [9:0]  pix_x, pix_y;
    logic [39:0] obs_vec;

    always #5 pclk = ~pclk;

    vga_sprite_engine #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(POL), .SCALE_SHIFT(SS), .NUM_RECT(NR)
    ) dut (
        .pclk(pclk), .reset_n(reset_n), .bg_color(bg_color),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
        .wr_w(wr_w), .wr_h(wr_h), .wr_color(wr_color),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .active(active), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
    );

    assign obs_vec = {hsync, vsync, red, green, blue, active, pix_x, pix_y, frame_start};

    int n_checks = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    // Tick count since reset release gives the screen position directly;
    // the output seen after tick n describes position n-1.
    int          p_x[NR], p_y[NR], p_w[NR], p_h[NR];
    logic [15:0] p_c[NR];
    int          l_x[NR], l_y[NR], l_w[NR], l_h[NR];
    logic [15:0] l_c[NR];
    int          m_cyc;
    int          m_q;
    logic [39:0] exp_vec = RST_VEC;

    function automatic logic [39:0] model_pixel(input int q);
        int h, v, x, y;
        bit act, found;
        logic hs, vs;
        logic [15:0] c;
        h = q % HT;
        v = q / HT;
        act = (h < HA) && (v < VA);
        hs = (h >= HA + HFP && h < HA + HFP + HSW) ? POL : !POL;
        vs = (v >= VA + VFP && v < VA + VFP + VSW) ? POL : !POL;
        c = 16'h0000;
        x = 0;
        y = 0;
        if (act) begin
            x = h / (1 << SS);
            y = v / (1 << SS);
            c = bg_color;
            found = 0;
            for (int i = 0; i < NR; i++) begin
                if (!found && x >= l_x[i] && x < l_x[i] + l_w[i] &&
                    y >= l_y[i] && y < l_y[i] + l_h[i]) begin
                    c = l_c[i];
                    found = 1;
                end
            end
        end
        return {hs, vs, c, act, 10'(x), 10'(y), 1'b0};
    endfunction

    always @(posedge pclk) begin
        if (!reset_n) begin
            m_cyc = 0;
            exp_vec = RST_VEC;
            for (int i = 0; i < NR; i++) begin
                p_x[i] = 0; p_y[i] = 0; p_w[i] = 0; p_h[i] = 0; p_c[i] = 16'h0;
                l_x[i] = 0; l_y[i] = 0; l_w[i] = 0; l_h[i] = 0; l_c[i] = 16'h0;
            end
        end else begin
            m_cyc++;
            exp_vec[0] = 1'b0;
            if (m_cyc % CLK_DIV == 0) begin
                m_q = (m_cyc / CLK_DIV - 1) % FRAME;
                exp_vec = model_pixel(m_q);
                if (m_q == FRAME - 1) begin
                    exp_vec[0] = 1'b1;
                    for (int i = 0; i < NR; i++) begin
                        l_x[i] = p_x[i]; l_y[i] = p_y[i]; l_w[i] = p_w[i];
                        l_h[i] = p_h[i]; l_c[i] = p_c[i];
                    end
                end
            end
            if (wr_en && int'(wr_idx) < NR) begin
                p_x[wr_idx] = int'(wr_x); p_y[wr_idx] = int'(wr_y);
                p_w[wr_idx] = int'(wr_w); p_h[wr_idx] = int'(wr_h);
                p_c[wr_idx] = wr_color;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_write(input int idx, input int x, input int y,
                             input int w, input int h, input logic [15:0] c);
        wr_en = 1'b1;
        wr_idx = 2'(idx);
        wr_x = 10'(x); wr_y = 10'(y); wr_w = 10'(w); wr_h = 10'(h);
        wr_color = c;
    endtask

    task automatic reset_hold();
        @(negedge pclk);
        reset_n = 1'b0;
        wr_en = 1'b0;
        repeat (3) @(negedge pclk);
    endtask

    task automatic wait_fs(output bit ok);
        ok = 0;
        for (int i = 0; i < FP_CYC + 4; i++) begin
            @(negedge pclk);
            if (frame_start) begin
                ok = 1;
                return;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bg_color = 16'h1234;
        reset_hold();
        n_checks++;
        if (obs_vec !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", obs_vec, RST_VEC);
        end
        reset_n = 1'b1;
        for (int j = 1; j <= FP_CYC; j++) begin
            @(negedge pclk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_model j=%0d: got %h expected %h", j, obs_vec, exp_vec);
            end
            if (j == CLK_DIV - 1) begin
                n_checks++;
                if (active !== 1'b0) begin
                    n_fail++;
                    $display("FAIL first_tick_early: active got %b expected 0", active);
                end
            end
            if (j == CLK_DIV) begin
                n_checks++;
                if (active !== 1'b1 || {red, green, blue} !== 16'h1234 || pix_x !== 10'd0) begin
                    n_fail++;
                    $display("FAIL first_tick: active=%b rgb=%h x=%0d expected 1 1234 0",
                             active, {red, green, blue}, pix_x);
                end
            end
        end
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL first_frame_start: got %b expected 1", frame_start);
        end
    endtask

    task automatic test_timing();
        int low_run, hs_width, last_fall, line_per, last_fs, fs_per;
        logic prev_hs;
        low_run = 0; hs_width = -1; last_fall = -1; line_per = -1;
        last_fs = -1; fs_per = -1;
        prev_hs = hsync;
        for (int i = 1; i <= 2 * FP_CYC + 8; i++) begin
            @(negedge pclk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL timing_model i=%0d: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (hsync == POL) begin
                low_run++;
                if (prev_hs != POL) begin
                    if (last_fall >= 0) line_per = i - last_fall;
                    last_fall = i;
                end
            end else begin
                if (prev_hs == POL) hs_width = low_run;
                low_run = 0;
            end
            if (frame_start) begin
                if (last_fs >= 0) fs_per = i - last_fs;
                last_fs = i;
            end
            prev_hs = hsync;
        end
        n_checks++;
        if (hs_width != HSW * CLK_DIV) begin
            n_fail++;
            $display("FAIL hsync_width: got %0d expected %0d", hs_width, HSW * CLK_DIV);
        end
        n_checks++;
        if (line_per != HT * CLK_DIV) begin
            n_fail++;
            $display("FAIL line_period: got %0d expected %0d", line_per, HT * CLK_DIV);
        end
        n_checks++;
        if (fs_per != FP_CYC) begin
            n_fail++;
            $display("FAIL frame_period: got %0d expected %0d", fs_per, FP_CYC);
        end
    endtask

    task automatic test_rect_basic();
        bit ok;
        int cnt_a, cnt_b;
        bg_color = 16'($urandom) & 16'h07FF;
        reset_hold();
        reset_n = 1'b1;
        wait_fs(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_wait_fs: got timeout expected frame_start");
            return;
        end
        cnt_a = 0; cnt_b = 0;
        for (int i = 1; i <= 2 * FP_CYC; i++) begin
            if (i == 200) set_write(0, 2, 1, 3, 2, 16'hF800);
            else wr_en = 1'b0;
            @(negedge pclk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL basic_model i=%0d: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (red == 5'd31 && green == 6'd0 && blue == 5'd0) begin
                if (i <= FP_CYC) cnt_a++;
                else cnt_b++;
            end
        end
        n_checks++;
        if (cnt_a != 0) begin
            n_fail++;
            $display("FAIL basic_same_frame: red cycles got %0d expected 0", cnt_a);
        end
        n_checks++;
        if (cnt_b != 48) begin
            n_fail++;
            $display("FAIL basic_next_frame: red cycles got %0d expected 48", cnt_b);
        end
    endtask

    task automatic test_overlap();
        bit ok;
        int cnt_g, cnt_b;
        bg_color = 16'($urandom) & 16'hF800;
        reset_hold();
        reset_n = 1'b1;
        wait_fs(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL overlap_wait_fs: got timeout expected frame_start");
            return;
        end
        cnt_g = 0; cnt_b = 0;
        for (int i = 1; i <= 2 * FP_CYC; i++) begin
            if (i == 100) set_write(0, 1, 1, 4, 3, 16'h07E0);
            else if (i == 101) set_write(1, 3, 2, 4, 3, 16'h001F);
            else wr_en = 1'b0;
            @(negedge pclk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL overlap_model i=%0d: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (i > FP_CYC && green == 6'd63) cnt_g++;
            if (i > FP_CYC && blue == 5'd31 && green == 6'd0) cnt_b++;
        end
        n_checks++;
        if (cnt_g != 96) begin
            n_fail++;
            $display("FAIL overlap_green: cycles got %0d expected 96", cnt_g);
        end
        n_checks++;
        if (cnt_b != 64) begin
            n_fail++;
            $display("FAIL overlap_blue: cycles got %0d expected 64", cnt_b);
        end
    endtask

    task automatic test_bad_idx();
        bit ok;
        int cnt;
        bg_color = 16'($urandom) & 16'h07FF;
        reset_hold();
        reset_n = 1'b1;
        wait_fs(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bad_idx_wait_fs: got timeout expected frame_start");
            return;
        end
        cnt = 0;
        for (int i = 1; i <= 2 * FP_CYC; i++) begin
            if (i == 100) set_write(3, 0, 0, 8, 6, 16'hF800);
            else wr_en = 1'b0;
            @(negedge pclk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL bad_idx_model i=%0d: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (red != 5'd0) cnt++;
        end
        n_checks++;
        if (cnt != 0) begin
            n_fail++;
            $display("FAIL bad_idx_visible: red cycles got %0d expected 0", cnt);
        end
    endtask

    task automatic test_commit_edge();
        bit ok;
        int blue_b, green_b, green_c;
        bg_color = 16'($urandom) & 16'hF800;
        reset_hold();
        reset_n = 1'b1;
        wait_fs(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL commit_wait_fs: got timeout expected frame_start");
            return;
        end
        blue_b = 0; green_b = 0; green_c = 0;
        for (int i = 1; i <= 3 * FP_CYC; i++) begin
            // i == FP_CYC lands the write on the commit edge itself
            if (i == FP_CYC - 1) set_write(1, 0, 0, 2, 2, 16'h001F);
            else if (i == FP_CYC) set_write(2, 4, 3, 2, 2, 16'h07E0);
            else wr_en = 1'b0;
            @(negedge pclk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL commit_model i=%0d: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (i > FP_CYC && i <= 2 * FP_CYC && blue == 5'd31) blue_b++;
            if (i > FP_CYC && i <= 2 * FP_CYC && green == 6'd63) green_b++;
            if (i > 2 * FP_CYC && green == 6'd63) green_c++;
        end
        n_checks++;
        if (blue_b != 32) begin
            n_fail++;
            $display("FAIL commit_early_write: cycles got %0d expected 32", blue_b);
        end
        n_checks++;
        if (green_b != 0) begin
            n_fail++;
            $display("FAIL commit_edge_too_soon: cycles got %0d expected 0", green_b);
        end
        n_checks++;
        if (green_c != 32) begin
            n_fail++;
            $display("FAIL commit_edge_late: cycles got %0d expected 32", green_c);
        end
    endtask

    task automatic test_right_edge();
        bit ok;
        int cnt_r, cnt_b, cnt_0;
        bg_color = 16'($urandom) & 16'h07E0;
        reset_hold();
        reset_n = 1'b1;
        wait_fs(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL edge_wait_fs: got timeout expected frame_start");
            return;
        end
        cnt_r = 0; cnt_b = 0; cnt_0 = 0;
        for (int i = 1; i <= 2 * FP_CYC; i++) begin
            if (i == 100) set_write(0, 6, 0, 10, 6, 16'hF800);
            else if (i == 101) set_write(1, 5, 0, 1020, 6, 16'h001F);
            else wr_en = 1'b0;
            @(negedge pclk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL edge_model i=%0d: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (i > FP_CYC) begin
                if (red == 5'd31) cnt_r++;
                if (blue == 5'd31 && red == 5'd0) cnt_b++;
                if (active && pix_x == 10'd0 && (red != 5'd0 || blue != 5'd0)) cnt_0++;
            end
        end
        n_checks++;
        if (cnt_r != 96) begin
            n_fail++;
            $display("FAIL edge_clip: red cycles got %0d expected 96", cnt_r);
        end
        n_checks++;
        if (cnt_b != 48) begin
            n_fail++;
            $display("FAIL edge_wide: blue cycles got %0d expected 48", cnt_b);
        end
        n_checks++;
        if (cnt_0 != 0) begin
            n_fail++;
            $display("FAIL edge_wrap: coloured cycles at x=0 got %0d expected 0", cnt_0);
        end
    endtask

    task automatic test_midframe_reset();
        logic [15:0] bg;
        bg = 16'($urandom) & 16'h07FF;
        bg_color = bg;
        reset_hold();
        reset_n = 1'b1;
        // Cover (0,0) with a committed rectangle, then reset part-way through
        // the next frame.
        for (int i = 1; i <= FP_CYC + 300; i++) begin
            if (i == 50) set_write(0, 0, 0, 8, 6, 16'hF800);
            else wr_en = 1'b0;
            @(negedge pclk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL mid_pre_model i=%0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        reset_hold();
        n_checks++;
        if (obs_vec !== RST_VEC) begin
            n_fail++;
            $display("FAIL mid_reset_values: got %h expected %h", obs_vec, RST_VEC);
        end
        reset_n = 1'b1;
        for (int j = 1; j <= FP_CYC; j++) begin
            @(negedge pclk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL mid_post_model j=%0d: got %h expected %h", j, obs_vec, exp_vec);
            end
            if (j == CLK_DIV) begin
                n_checks++;
                if (active !== 1'b1 || {red, green, blue} !== bg) begin
                    n_fail++;
                    $display("FAIL mid_restart: active=%b rgb=%h expected 1 %h",
                             active, {red, green, blue}, bg);
                end
            end
        end
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_frame_start: got %b expected 1", frame_start);
        end
    endtask

    task automatic test_random();
        bg_color = 16'($urandom);
        reset_hold();
        reset_n = 1'b1;
        for (int i = 1; i <= 4 * FP_CYC; i++) begin
            if ($urandom_range(0, 39) == 0)
                set_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 6)),
                          int'($urandom_range(0, 5)), 16'($urandom));
            else
                wr_en = 1'b0;
            if ($urandom_range(0, 299) == 0) bg_color = 16'($urandom);
            @(negedge pclk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random_model i=%0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        wr_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_timing();
        test_rect_basic();
        test_overlap();
        test_bad_idx();
        test_commit_edge();
        test_right_edge();
        test_midframe_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
